// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: opcode encodings
// and the result-flag bundle produced by the final pipeline stage.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic c_out;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder built from full adders; also exposes
// the carry into the slice MSB so the caller can derive signed overflow.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c[0] = ci;
        s    = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipe_rca.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit ripple slice per stage with
// the carry registered between stages and valid/ready flow control.
module pipe_rca
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    flags_t           flags_d;
    flags_t           flags_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operands are masked on bubbles so an idle producer never leaks X into the data path.
    always_comb begin
        a_cap   = '0;
        b_eff   = '0;
        cin_eff = 1'b0;
        if (in_valid) begin
            a_cap   = A;
            b_eff   = (sub == OP_SUB) ? ~B : B;
            cin_eff = (sub == OP_SUB) ? ~c_in : c_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK;

        logic [CHUNK-1:0] a_sl;
        logic [CHUNK-1:0] b_sl;
        logic [CHUNK-1:0] sum;
        logic             ci;
        logic             co;
        logic             v_d;
        logic             v_q;
        logic [HI-1:0]    s_d;
        logic [HI-1:0]    s_q;

        if (k == 0) begin : g_src
            always_comb begin
                a_sl = a_cap[HI-1:LO];
                b_sl = b_eff[HI-1:LO];
                ci   = cin_eff;
                v_d  = in_valid;
                s_d  = sum;
            end
        end else begin : g_src
            // Lower result slices ride along so the full word emerges aligned.
            always_comb begin
                a_sl = g_stage[k-1].g_fwd.a_q[HI-1:LO];
                b_sl = g_stage[k-1].g_fwd.b_q[HI-1:LO];
                ci   = g_stage[k-1].g_fwd.c_q;
                v_d  = g_stage[k-1].v_q;
                s_d  = {sum, g_stage[k-1].s_q};
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic c_msb;
            rca_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a        (a_sl),
                .b        (b_sl),
                .ci       (ci),
                .s        (sum),
                .co       (co),
                .c_msb_in (c_msb)
            );
        end else begin : g_mid
            logic c_msb_unused;
            rca_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a        (a_sl),
                .b        (b_sl),
                .ci       (ci),
                .s        (sum),
                .co       (co),
                .c_msb_in (c_msb_unused)
            );
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:HI] a_d;
            logic [WIDTH-1:HI] b_d;
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;
            logic              c_d;
            logic              c_q;

            if (k == 0) begin : g_in
                always_comb begin
                    a_d = a_cap[WIDTH-1:HI];
                    b_d = b_eff[WIDTH-1:HI];
                end
            end else begin : g_in
                always_comb begin
                    a_d = g_stage[k-1].g_fwd.a_q[WIDTH-1:HI];
                    b_d = g_stage[k-1].g_fwd.b_q[WIDTH-1:HI];
                end
            end

            assign c_d = co;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                    c_q <= c_d;
                end
            end
        end

        // NOTE: non-blocking assignments let every stage sample its neighbour's old value on the same edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                s_q <= s_d;
            end
        end
    end

    always_comb begin
        flags_d.c_out = g_stage[STAGES-1].co;
        flags_d.ovf   = g_stage[STAGES-1].g_last.c_msb ^ g_stage[STAGES-1].co;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (adv) begin
            flags_q <= flags_d;
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign S         = g_stage[STAGES-1].s_q;
    assign c_out     = flags_q.c_out;
    assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_pipe_rca.sv
// Directed and randomised checks of pipe_rca in the 4-stage and 1-stage
// configurations, including stalls and mid-flight reset.
module tb_pipe_rca;
    import adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, s;
    logic        in_valid1, in_ready1, c_in1, sub1, out_valid1, out_ready1, c_out1, ovf1;
    logic [15:0] a1, b1, s1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_rca #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .S(s), .c_out(c_out), .ovf(ovf)
    );

    pipe_rca #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(a1), .B(b1), .c_in(c_in1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .S(s1), .c_out(c_out1), .ovf(ovf1)
    );

    localparam logic [15:0] DIR_A [5] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    localparam logic [15:0] DIR_B [5] = '{16'h0007, 16'hFFFF, 16'h0001, 16'h0007, 16'h0001};
    localparam logic        DIR_C [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic        DIR_OP[5] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    localparam logic [17:0] DIR_E [5] = '{{2'b00, 16'h0008}, {2'b01, 16'hFFFF},
                                          {2'b10, 16'h8000}, {2'b00, 16'hFFFE},
                                          {2'b11, 16'h7FFF}};

    // Reference result {ovf, c_out, S}; overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic op);
        logic [15:0] ye;
        logic        ce;
        logic [16:0] r;
        logic        o;
        ye = op ? ~y : y;
        ce = op ? ~ci : ci;
        r  = {1'b0, x} + {1'b0, ye} + {16'h0, ce};
        o  = (x[15] == ye[15]) && (r[15] != x[15]);
        return {o, r[16], r[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        #2;
        checks++;
        if ({out_valid, s, c_out, ovf, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_during: got %h expected %h", {out_valid, s, c_out, ovf, in_ready},
                     {1'b0, 16'h0, 1'b0, 1'b0, 1'b1});
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({out_valid, s, c_out, ovf, in_ready, out_valid1, s1} !== {1'b0, 16'h0, 3'b001, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_after: got %h expected %h",
                     {out_valid, s, c_out, ovf, in_ready, out_valid1, s1}, {1'b0, 16'h0, 3'b001, 1'b0, 16'h0});
        end
    endtask

    task automatic test_directed();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = DIR_A[i]; b = DIR_B[i]; c_in = DIR_C[i]; sub = DIR_OP[i];
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
            end
            checks++;
            if ({out_valid, ovf, c_out, s} !== {1'b1, DIR_E[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h expected %h", i, {out_valid, ovf, c_out, s},
                         {1'b1, DIR_E[i]});
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_retire[%0d]: got out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] q[$];
        logic [17:0] exp_r;
        logic [15:0] held;
        int sent = 0, got = 0, cyc = 0;
        while (got < 8 && cyc < 60) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                a = 16'(sent * 16'h1111); b = 16'h0F0F + 16'(sent);
                c_in = sent[1]; sub = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checks++;
                if ({in_ready, out_valid} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_stall_ready: got in_ready/out_valid=%b expected 01", {in_ready, out_valid});
                end
                if (cyc == 6) held = s;
                else begin
                    checks++;
                    if (s !== held) begin
                        errors++;
                        $display("FAIL b2b_stall_hold: got %h expected %h", s, held);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got result %h expected none", s);
                end else begin
                    exp_r = q.pop_front();
                    if ({ovf, c_out, s} !== exp_r) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %h expected %h", got, {ovf, c_out, s}, exp_r);
                    end
                end
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 8 || sent != 8 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d/%0d pending %0d expected 8/8 pending 0", got, sent, q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_dup: got out_valid=%b expected 0", out_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h0100 + 16'(i); b = 16'h0022; c_in = 1'b0; sub = OP_ADD;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, s} !== {1'b1, 16'h0122}) begin
            errors++;
            $display("FAIL rstmid_pre: got %h expected %h", {out_valid, s}, {1'b1, 16'h0122});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, s, c_out, ovf, in_ready} !== {1'b0, 16'h0, 3'b001}) begin
            errors++;
            $display("FAIL rstmid_async: got %h expected %h", {out_valid, s, c_out, ovf, in_ready},
                     {1'b0, 16'h0, 3'b001});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_stale: got %0d results expected 0", seen);
        end
        in_valid = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = OP_ADD;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if ({out_valid, ovf, c_out, s} !== {3'b100, 16'h5555} || lat != 4) begin
            errors++;
            $display("FAIL rstmid_after: got %h lat %0d expected %h lat 4", {out_valid, ovf, c_out, s}, lat,
                     {3'b100, 16'h5555});
        end
        tick();
    endtask

    task automatic test_single_stage();
        logic [15:0] va [3] = '{16'h00FF, 16'h0000, 16'h8000};
        logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'h8000};
        logic        vs [3] = '{OP_ADD, OP_SUB, OP_ADD};
        logic [17:0] ve [3] = '{{2'b00, 16'h0100}, {2'b00, 16'hFFFF}, {2'b11, 16'h0000}};
        out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid1 = 1'b1; a1 = va[i]; b1 = vb[i]; c_in1 = 1'b0; sub1 = vs[i];
            tick();
            in_valid1 = 1'b0;
            checks++;
            if ({out_valid1, ovf1, c_out1, s1} !== {1'b1, ve[i]}) begin
                errors++;
                $display("FAIL single_stage[%0d]: got %h expected %h", i, {out_valid1, ovf1, c_out1, s1},
                         {1'b1, ve[i]});
            end
            tick();
            checks++;
            if (out_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL single_stage_retire[%0d]: got %b expected 0", i, out_valid1);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] exp_r;
        logic [17:0] prev_out;
        logic        prev_stall = 1'b0;
        int sent = 0, got = 0, cyc = 0;
        localparam int N = 10000;
        while (got < N && cyc < 60000) begin
            in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (prev_stall) begin
                checks++;
                if ({out_valid, ovf, c_out, s} !== {1'b1, prev_out}) begin
                    errors++;
                    $display("FAIL rand_hold: got %h expected %h", {out_valid, ovf, c_out, s}, {1'b1, prev_out});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {ovf, c_out, s};
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got result %h expected none", s);
                end else begin
                    exp_r = q.pop_front();
                    if ({ovf, c_out, s} !== exp_r) begin
                        errors++;
                        $display("FAIL rand_result[%0d]: got %h expected %h", got, {ovf, c_out, s}, exp_r);
                    end
                end
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != N || q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got %0d pending %0d expected %0d pending 0", got, q.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_single_stage();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
